// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to a
// variable-latency instruction memory and hands instructions to decode.
module stage_if #(
  parameter int unsigned           INST_WIDTH = 32,
  parameter int unsigned           PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCSrc,
  input  logic [PC_WIDTH-1:0]   PCTarget,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] Instruction,
  output logic [PC_WIDTH-1:0]   PC,
  output logic [PC_WIDTH-1:0]   PCPlus4
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [INST_WIDTH-1:0] NOP     = {{(INST_WIDTH-7){1'b0}}, 7'h13};
  localparam logic [PC_WIDTH-1:0]   PC_FOUR = {{(PC_WIDTH-3){1'b0}}, 3'd4};

  logic [1:0]            state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                  kill_q, kill_d;
  logic                  req_q, req_d;
  logic [PC_WIDTH-1:0]   addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   pc4_q, pc4_d;
  logic [PC_WIDTH-1:0]   target;
  logic                  unused_target_lsbs;

  assign target             = {PCTarget[PC_WIDTH-1:2], 2'b00};
  assign unused_target_lsbs = ^PCTarget[1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    req_d      = req_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = fetch_pc_q;
      end
      FETCH: begin
        if (req_q) begin
          if (imem_rvalid) begin
            req_d = 1'b0;
            if (kill_q || PCSrc) begin
              // Stale response: drop it, idle the request for one cycle, refetch.
              kill_d = 1'b0;
              if (PCSrc) fetch_pc_d = target;
            end else begin
              inst_d  = imem_rdata;
              pc_d    = fetch_pc_q;
              pc4_d   = fetch_pc_q + PC_FOUR;
              valid_d = 1'b1;
              state_d = HOLD;
            end
          end else if (PCSrc) begin
            kill_d     = 1'b1;
            fetch_pc_d = target;
          end
        end else begin
          // Gap cycle after a discarded response; a redirect here needs no kill.
          if (PCSrc) fetch_pc_d = target;
          req_d  = 1'b1;
          addr_d = fetch_pc_d;
        end
      end
      HOLD: begin
        if (PCSrc) begin
          valid_d    = 1'b0;
          fetch_pc_d = target;
          state_d    = FETCH;
          req_d      = 1'b1;
          addr_d     = target;
        end else if (valid_q && inst_ready) begin
          valid_d    = 1'b0;
          fetch_pc_d = pc4_q;
          state_d    = FETCH;
          req_d      = 1'b1;
          addr_d     = pc4_q;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      valid_q    <= 1'b0;
      inst_q     <= NOP;
      pc_q       <= RESET_PC;
      pc4_q      <= RESET_PC + PC_FOUR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst_valid  = valid_q;
  assign Instruction = inst_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc4_q;

endmodule
